// File: rtl/dense_25d_ctrl_pkg.sv
// Shared types and constants for the 2.5D dense layer controller and its helpers.
package dense_25d_ctrl_pkg;

   localparam int PIX_W = 8;
   localparam int ACC_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_e;

   // Bits needed to hold every value 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/dense_25d_ctrl_latency_down_counter.sv
// Loadable down counter with an expire flag raised while the count sits at 1.
module latency_down_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   // NOTE: next-state logic assigns its default first, so no path leaves cnt_d unassigned (no latch).
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/dense_25d_ctrl.sv
// Sequencer for the 2.5D dense datapath: gates one window of pixel vectors in,
// waits out the tree latency, and hands the captured result downstream.
module dense_25d_ctrl
   import dense_25d_ctrl_pkg::*;
#(
   parameter int Z_DEPTH      = 4,
   parameter int NUM_TREES    = 4,
   parameter int MA_TREE_SIZE = 9,
   parameter int PIPE_LATENCY = 6,
   parameter int CNT_W        = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [CNT_W-1:0]             num_windows,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PIX_W*Z_DEPTH-1:0]     in_pixels,
   output logic [PIX_W*Z_DEPTH-1:0]     dp_pixels,
   output logic                         dp_shift_en,
   input  logic [ACC_W*NUM_TREES-1:0]   dp_result,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_W*NUM_TREES-1:0]   out_data,
   output logic                         busy,
   output logic                         done
);

   localparam int FILL_W = cnt_width(MA_TREE_SIZE);
   localparam int LAT_W  = cnt_width(PIPE_LATENCY);
   localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(MA_TREE_SIZE);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(MA_TREE_SIZE - 1);
   localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(PIPE_LATENCY);

   state_e                        state_q, state_d;
   logic [FILL_W-1:0]             fill_cnt_q, fill_cnt_d;
   logic [CNT_W-1:0]              remaining_q, remaining_d;
   logic [PIX_W*Z_DEPTH-1:0]      dp_pixels_q, dp_pixels_d;
   logic                          dp_shift_en_q, dp_shift_en_d;
   logic                          out_valid_q, out_valid_d;
   logic [ACC_W*NUM_TREES-1:0]    out_data_q, out_data_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;

   logic lat_load, lat_dec, lat_expire;
   logic in_hs, out_hs;

   assign in_ready = (state_q == FILL) && (fill_cnt_q < FILL_MAX);
   assign in_hs    = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready;

   latency_down_counter #(.W(LAT_W)) u_lat_cnt (
      .clk      (clock),
      .rst_n    (reset),
      .load     (lat_load),
      .load_val (LAT_LOAD),
      .dec      (lat_dec),
      .expire   (lat_expire)
   );

   always_comb begin
      state_d       = state_q;
      fill_cnt_d    = fill_cnt_q;
      remaining_d   = remaining_q;
      dp_pixels_d   = '0;
      dp_shift_en_d = 1'b0;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      done_d        = 1'b0;
      lat_load      = 1'b0;
      lat_dec       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               remaining_d = num_windows;
               if (num_windows == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d    = FILL;
                  fill_cnt_d = '0;
               end
            end
         end
         FILL: begin
            if (in_hs) begin
               dp_pixels_d   = in_pixels;
               dp_shift_en_d = 1'b1;
               fill_cnt_d    = fill_cnt_q + FILL_W'(1);
               if (fill_cnt_q == FILL_LAST) begin
                  state_d  = DRAIN;
                  lat_load = 1'b1;
               end
            end
         end
         DRAIN: begin
            // Latency is counted from the end of the final shift cycle, so hold during it.
            lat_dec = !dp_shift_en_q;
            if (lat_dec && lat_expire) begin
               out_data_d  = dp_result;
               out_valid_d = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (out_hs) begin
               out_valid_d = 1'b0;
               if (remaining_q != '0) begin
                  remaining_d = remaining_q - CNT_W'(1);
               end
               if (remaining_q <= CNT_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d    = FILL;
                  fill_cnt_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         fill_cnt_q    <= '0;
         remaining_q   <= '0;
         dp_pixels_q   <= '0;
         dp_shift_en_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         fill_cnt_q    <= fill_cnt_d;
         remaining_q   <= remaining_d;
         dp_pixels_q   <= dp_pixels_d;
         dp_shift_en_q <= dp_shift_en_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign dp_pixels   = dp_pixels_q;
   assign dp_shift_en = dp_shift_en_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_dense_25d_ctrl.sv
// Directed bench for dense_25d_ctrl; dp_result follows a free-running cycle count
// so the capture instant is visible in out_data.
module tb_dense_25d_ctrl;

   logic          clock;
   logic          reset;
   logic          start;
   logic [15:0]   num_windows;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_pixels;
   logic [31:0]   dp_pixels;
   logic          dp_shift_en;
   logic [127:0]  dp_result;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_data;
   logic          busy;
   logic          done;

   logic [31:0]   cyc = 32'd0;
   int            total = 0;
   int            bad = 0;

   dense_25d_ctrl #(
      .Z_DEPTH(4), .NUM_TREES(4), .MA_TREE_SIZE(9), .PIPE_LATENCY(6), .CNT_W(16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .num_windows (num_windows),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pixels   (in_pixels),
      .dp_pixels   (dp_pixels),
      .dp_shift_en (dp_shift_en),
      .dp_result   (dp_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy),
      .done        (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 32'd1;

   function automatic logic [127:0] res_of(input logic [31:0] t);
      res_of = {t + 32'd3, t + 32'd2, t + 32'd1, t};
   endfunction

   function automatic logic [31:0] pix(input int i);
      pix = {8'(i + 48), 8'(i + 32), 8'(i + 16), 8'(i)};
   endfunction

   assign dp_result = res_of(cyc);

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start(input int n);
      start       = 1'b1;
      num_windows = 16'(n);
      step();
      start       = 1'b0;
   endtask

   // Feeds one window; gaps selects the 1,0,0 valid pattern; a start pulse is
   // injected at accept index start_at (negative disables). Returns cyc after the 9th accept.
   task automatic feed_window(input bit gaps, input int base, input int start_at,
                              output logic [31:0] t9);
      int          accepted = 0;
      int          guard = 0;
      bit          v;
      logic [31:0] exp_pix;
      while (accepted < 9 && guard < 100) begin
         v         = gaps ? (guard % 3 == 0) : 1'b1;
         in_valid  = v;
         in_pixels = pix(base + accepted);
         exp_pix   = v ? pix(base + accepted) : 32'd0;
         if (accepted == start_at && v) begin
            start       = 1'b1;
            num_windows = 16'd7;
         end
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL fill_in_ready acc=%0d got=%b want=1", accepted, in_ready);
         end
         step();
         start = 1'b0;
         total++;
         if ({dp_shift_en, dp_pixels} !== {v, exp_pix}) begin
            bad++;
            $display("FAIL fill_shift acc=%0d got=%b/%h want=%b/%h",
                     accepted, dp_shift_en, dp_pixels, v, exp_pix);
         end
         if (v) accepted++;
         guard++;
      end
      if (accepted != 9) begin
         bad++;
         $display("FAIL fill_timeout got=%0d want=9", accepted);
      end
      in_valid = 1'b1;
      t9 = cyc;
   endtask

   task automatic drain_window(input logic [31:0] t9, input int stall, input bit last);
      logic [127:0] exp_res;
      exp_res = res_of(t9 + 32'd6);
      for (int k = 1; k <= 7; k++) begin
         step();
         total++;
         if ({out_valid, in_ready, dp_shift_en} !== {(k == 7), 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL drain_timing k=%0d got=%b%b%b want=%b00",
                     k, out_valid, in_ready, dp_shift_en, (k == 7));
         end
      end
      in_valid = 1'b0;
      total++;
      if (out_data !== exp_res) begin
         bad++;
         $display("FAIL out_data got=%h want=%h", out_data, exp_res);
      end
      for (int s = 0; s < stall; s++) begin
         step();
         total++;
         if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp_res}) begin
            bad++;
            $display("FAIL stall s=%0d got=%b%b/%h want=10/%h", s, out_valid, in_ready, out_data, exp_res);
         end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++;
      if ({out_valid, done, busy, in_ready} !== {1'b0, last, !last, !last}) begin
         bad++;
         $display("FAIL out_hs got=%b%b%b%b want=0%b%b%b",
                  out_valid, done, busy, in_ready, last, !last, !last);
      end
      if (last) begin
         step();
         total++;
         if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL done_pulse got=%b%b want=00", done, busy);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3 reset = 1'b0;
      #3;
      total++;
      if ({in_ready, dp_shift_en, out_valid, busy, done, dp_pixels, out_data} !== '0) begin
         bad++;
         $display("FAIL reset_state got=%b%b%b%b%b/%h/%h",
                  in_ready, dp_shift_en, out_valid, busy, done, dp_pixels, out_data);
      end
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_single();
      logic [31:0] t9;
      do_start(1);
      total++;
      if ({busy, in_ready} !== 2'b11) begin
         bad++;
         $display("FAIL single_start got=%b%b want=11", busy, in_ready);
      end
      feed_window(1'b0, 1, -1, t9);
      drain_window(t9, 0, 1'b1);
   endtask

   task automatic test_zero();
      do_start(0);
      total++;
      if ({done, busy, in_ready, dp_shift_en} !== 4'b1000) begin
         bad++;
         $display("FAIL zero_done got=%b%b%b%b want=1000", done, busy, in_ready, dp_shift_en);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if ({done, busy, in_ready, dp_shift_en} !== 4'b0000) begin
            bad++;
            $display("FAIL zero_idle i=%0d got=%b%b%b%b want=0000", i, done, busy, in_ready, dp_shift_en);
         end
      end
   endtask

   task automatic test_gaps();
      logic [31:0] t9;
      do_start(1);
      feed_window(1'b1, 10, -1, t9);
      drain_window(t9, 0, 1'b1);
   endtask

   task automatic test_stall();
      logic [31:0] t9;
      do_start(2);
      feed_window(1'b0, 20, -1, t9);
      drain_window(t9, 20, 1'b0);
      feed_window(1'b0, 40, -1, t9);
      drain_window(t9, 0, 1'b1);
   endtask

   task automatic test_start_in_fill();
      logic [31:0] t9;
      do_start(2);
      feed_window(1'b0, 60, 3, t9);
      drain_window(t9, 0, 1'b0);
      feed_window(1'b0, 80, -1, t9);
      drain_window(t9, 0, 1'b1);
      step();
      total++;
      if ({busy, in_ready, done} !== 3'b000) begin
         bad++;
         $display("FAIL start_ignored got=%b%b%b want=000", busy, in_ready, done);
      end
   endtask

   task automatic test_reset_mid_drain();
      logic [31:0] t9;
      do_start(3);
      feed_window(1'b0, 100, -1, t9);
      in_valid = 1'b0;
      step();
      step();
      step();
      #2 reset = 1'b0;
      #1;
      total++;
      if ({in_ready, dp_shift_en, out_valid, busy, done, dp_pixels, out_data} !== '0) begin
         bad++;
         $display("FAIL mid_reset got=%b%b%b%b%b/%h/%h",
                  in_ready, dp_shift_en, out_valid, busy, done, dp_pixels, out_data);
      end
      step();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({busy, done, out_valid} !== 3'b000) begin
            bad++;
            $display("FAIL post_reset i=%0d got=%b%b%b want=000", i, busy, done, out_valid);
         end
      end
      do_start(1);
      feed_window(1'b0, 120, -1, t9);
      drain_window(t9, 0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      start       = 1'b0;
      num_windows = 16'd0;
      in_valid    = 1'b0;
      in_pixels   = 32'd0;
      out_ready   = 1'b0;
      test_reset();
      test_single();
      test_zero();
      test_gaps();
      test_stall();
      test_start_in_fill();
      test_reset_mid_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dense_25d_ctrl.md
Name: dense_25d_ctrl

Overview:
- Sequencer for the 2.5D dense datapath (parallel 2D dense slices summed across Z by 32-bit adder trees).
- Accepts a stream of Z_DEPTH-wide 8-bit pixel vectors and gates exactly MA_TREE_SIZE vectors per output window into the datapath.
- Waits out the fixed multiply/adder-tree latency, captures the NUM_TREES x 32-bit result, and hands it downstream with valid/ready.
- Repeats for a programmed number of windows, then pulses done.

Parameters:
- Z_DEPTH, 4, pixel lanes per vector (kernels in previous layer).
- NUM_TREES, 4, output lanes (32 bit each).
- MA_TREE_SIZE, 9, pixel vectors per output window.
- PIPE_LATENCY, 6, clocks from the last dp_shift_en to a stable dp_result; must be at least 1.
- CNT_W, 16, width of the window counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a run; honoured only in IDLE.
- num_windows  in  CNT_W  windows to process; sampled on start.
- in_valid  in  1  in_pixels valid.
- in_ready  out  1  controller accepts in_pixels.
- in_pixels  in  8*Z_DEPTH  pixel vector, lane i at [8i+7:8i].
- dp_pixels  out  8*Z_DEPTH  registered vector to the datapath; zero when dp_shift_en=0.
- dp_shift_en  out  1  datapath shift-register advance enable.
- dp_result  in  32*NUM_TREES  datapath output.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  32*NUM_TREES  captured result, registered.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at run completion.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; all counters 0. Reset asserted mid-run aborts the run: no done pulse, partial window discarded.
- IDLE:
  - start=1 latches num_windows into remaining.
  - remaining==0 -> done=1 on the next cycle, stay in IDLE.
  - Otherwise -> FILL with fill_cnt=0.
- FILL:
  - in_ready = (fill_cnt < MA_TREE_SIZE). Purely combinational from state and counter, never from in_valid.
  - Each handshake (in_valid & in_ready) registers in_pixels into dp_pixels, sets dp_shift_en=1 for exactly the next cycle, and increments fill_cnt.
  - in_valid low: fill_cnt holds, dp_shift_en=0, dp_pixels=0. Gaps are legal.
  - Handshake that makes fill_cnt reach MA_TREE_SIZE -> DRAIN with lat_cnt=PIPE_LATENCY.
- DRAIN:
  - in_ready=0; lat_cnt decrements every cycle.
  - At lat_cnt==1: out_data <= dp_result, then -> OUT.
  - out_valid therefore rises exactly PIPE_LATENCY+1 clocks after the edge of the final input handshake, i.e. PIPE_LATENCY clocks after the final dp_shift_en cycle.
- OUT:
  - out_valid=1; out_data stable until out_valid & out_ready. out_ready held low stalls indefinitely, with in_ready held at 0.
  - On handshake: out_valid=0 next cycle; remaining decrements.
  - remaining becomes 0 -> done=1 for one cycle, -> IDLE.
  - Otherwise -> FILL with fill_cnt=0; in_ready is high the cycle after the handshake.
- start outside IDLE is ignored.
- busy=0 in the cycle done is high.
- Arithmetic and widths:
  - fill_cnt width $clog2(MA_TREE_SIZE+1); lat_cnt width $clog2(PIPE_LATENCY+1).
  - remaining is CNT_W bits and never wraps (decrement only from a value of 1 or more).
- Pure controller: no arithmetic on pixel or result data.

Decomposition:
- Shared package holds:
  - state enum: IDLE, FILL, DRAIN, OUT.
  - localparam functions for fill_cnt and lat_cnt widths.
  - PIX_W=8 and ACC_W=32 constants.
- One natural sub-module: latency_down_counter (load, decrement, expire flag). Used for lat_cnt; reusable by other layer controllers.
- The FSM stays in dense_25d_ctrl.

Test Plan:
- Reset mid-DRAIN with num_windows=3 -> next cycle all outputs 0, busy=0, no done pulse; a fresh start then runs normally.
- start, num_windows=1, in_valid held high with vectors 1..9 -> in_ready high 9 cycles; dp_shift_en high 9 consecutive cycles carrying 1..9; out_valid high 7 clocks after the last accept (PIPE_LATENCY=6); out_data equals the dp_result sampled by the model; done pulses one cycle after the out handshake.
- num_windows=0 -> done high on the cycle after start; in_ready and dp_shift_en never assert; busy stays 0.
- in_valid toggled 1,0,0,1,... in FILL -> dp_shift_en only after true handshakes; exactly 9 shifts per window; out_valid timing measured from the 9th accept still 7 clocks.
- out_ready held low 20 cycles in OUT, num_windows=2 -> out_data stable, in_ready=0 throughout; after the handshake in_ready=1 next cycle; second window completes; done after the second handshake only.
- start pulsed during FILL -> ignored; remaining is unchanged and the run completes with the original window count.
